// File: rtl/ni_pkg.sv
// ni_pkg: flit info codes, default widths and field offset helpers shared across the network interface
package ni_pkg;
    localparam int INFO_W_DEF   = 4;
    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int PE_IDX_W_DEF = 6;
    localparam int ACT_NO_W_DEF = 6;

    localparam logic [3:0] INFO_BROADCAST     = 4'h0;
    localparam logic [3:0] INFO_FIN_BROADCAST = 4'h1;
    localparam logic [3:0] INFO_FIN_COMP      = 4'h2;
    localparam logic [3:0] INFO_READ          = 4'h3;

    // Flits are packed {info, addr, data} with data in the least significant bits
    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int info_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction
endpackage

// File: rtl/ni_flit_fifo.sv
// ni_flit_fifo: synchronous FIFO with full, empty and occupancy count
module ni_flit_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ni_output_queue.sv
// ni_output_queue: lossless PE output unit, fixed-priority arbiter into a local queue drained by a credit launcher
module ni_output_queue
    import ni_pkg::*;
#(
    parameter int INFO_W      = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int PE_IDX_W    = 6,
    parameter int ACT_NO_W    = 6,
    parameter int QUEUE_DEPTH = 4,
    parameter int CREDIT_INIT = 4,
    parameter int CREDIT_W    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PE_IDX_W-1:0]             pe_idx,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [ADDR_W-1:0]               act_addr,
    input  logic [DATA_W-1:0]               act_data,
    input  logic                            fin_comp,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    input  logic [ACT_NO_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]               rd_data,
    input  logic                            downstream_credit,
    output logic                            router_rdy,
    output logic                            out_data_valid,
    output logic [INFO_W+ADDR_W+DATA_W-1:0] out_data
);
    localparam int FW = INFO_W + ADDR_W + DATA_W;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic                full, empty, fin_pend, launch, act_g, fin_g, rd_g;
    logic [FW-1:0]       flit, head;
    logic [CW-1:0]       count;
    logic [CREDIT_W-1:0] credit_count;

    assign act_ready  = !rst && !full;
    assign rd_ready   = !rst && !full && !act_valid && !fin_pend;
    assign act_g      = act_valid && act_ready;
    assign fin_g      = !rst && !full && !act_valid && fin_pend;
    assign rd_g       = rd_valid && rd_ready;
    assign router_rdy = credit_count != '0;
    assign launch     = !empty && router_rdy;

    assign flit = act_g ? {act_addr[ADDR_W-1] ? INFO_W'(INFO_FIN_BROADCAST) : INFO_W'(INFO_BROADCAST), act_addr, act_data}
                : fin_g ? {INFO_W'(INFO_FIN_COMP), ADDR_W'(0), DATA_W'(pe_idx)}
                :         {INFO_W'(INFO_READ), ADDR_W'({rd_addr, pe_idx}), rd_data};

    ni_flit_fifo #(.WIDTH(FW), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (act_g || fin_g || rd_g),
        .pop   (launch),
        .din   (flit),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fin_pend       <= 1'b0;
            credit_count   <= CREDIT_W'(CREDIT_INIT);
            out_data_valid <= 1'b0;
            out_data       <= '0;
        end else begin
            // A pulse coinciding with the grant re-arms the flag for a second FIN_COMP
            fin_pend       <= fin_comp || (fin_pend && !fin_g);
            out_data_valid <= launch;
            out_data       <= launch ? head : '0;
            if (launch && !downstream_credit)
                credit_count <= credit_count - 1'b1;
            else if (!launch && downstream_credit && credit_count != CREDIT_W'(CREDIT_INIT))
                credit_count <= credit_count + 1'b1;
        end
    end

    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(downstream_credit && !launch && credit_count == CREDIT_W'(CREDIT_INIT)));
    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(QUEUE_DEPTH));
endmodule

// File: tb/tb_ni_output_queue.sv
// tb_ni_output_queue: scenario tasks plus randomized traffic checked against a queue-based reference model
module tb_ni_output_queue;
    logic        clk = 0, rst = 1;
    logic [5:0]  pe_idx = 0, rd_addr = 0;
    logic        act_valid = 0, fin_comp = 0, rd_valid = 0, downstream_credit = 0;
    logic [15:0] act_addr = 0, act_data = 0, rd_data = 0;
    logic        act_ready, rd_ready, router_rdy, out_data_valid;
    logic [35:0] out_data;

    int total = 0, bad = 0;

    logic [35:0] mq[$];
    bit          m_fin = 0, m_ov = 0;
    int          m_cred = 4;
    logic [35:0] m_od = 0;

    ni_output_queue dut (
        .clk(clk), .rst(rst), .pe_idx(pe_idx),
        .act_valid(act_valid), .act_ready(act_ready), .act_addr(act_addr), .act_data(act_data),
        .fin_comp(fin_comp),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .downstream_credit(downstream_credit), .router_rdy(router_rdy),
        .out_data_valid(out_data_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        bit full, launch, ag, fg, rg;
        logic [35:0] f;
        full   = mq.size() == 4;
        launch = !rst && mq.size() > 0 && m_cred > 0;
        ag     = !rst && !full && act_valid;
        fg     = !rst && !full && !act_valid && m_fin;
        rg     = !rst && !full && !act_valid && !m_fin && rd_valid;
        f = ag ? {act_addr[15] ? 4'h1 : 4'h0, act_addr, act_data}
          : fg ? {4'h2, 16'h0, 10'h0, pe_idx}
          :      {4'h3, 4'h0, rd_addr, pe_idx, rd_data};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_fin = 0; m_cred = 4; m_ov = 0; m_od = 0;
        end else begin
            m_ov = launch;
            m_od = launch ? mq.pop_front() : 36'h0;
            if (ag || fg || rg) mq.push_back(f);
            m_fin = fin_comp || (m_fin && !fg);
            if (launch && !downstream_credit) m_cred--;
            else if (!launch && downstream_credit && m_cred < 4) m_cred++;
        end
    endtask

    task automatic do_reset();
        rst = 1; act_valid = 0; fin_comp = 0; rd_valid = 0; downstream_credit = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; act_valid = 1; rd_valid = 1;
        #1;
        total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL reset_act_ready got=%b exp=0", act_ready); end
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%b exp=0", rd_ready); end
        tick();
        total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_data_valid); end
        total++; if (out_data !== 36'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (router_rdy !== 1'b1) begin bad++; $display("FAIL reset_router_rdy got=%b exp=1", router_rdy); end
        rst = 0; act_valid = 0; rd_valid = 0;
    endtask

    task automatic test_broadcast();
        do_reset();
        act_valid = 1; act_addr = 16'h0005; act_data = 16'h1234;
        #1;
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", act_ready); end
        tick();
        act_valid = 0;
        total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL bc_early got=%b exp=0", out_data_valid); end
        tick();
        total++; if (out_data_valid !== 1'b1 || out_data !== 36'h0_0005_1234)
            begin bad++; $display("FAIL bc_flit got=%b/%h exp=1/000051234", out_data_valid, out_data); end
        tick();
        total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL bc_one_cycle got=%b exp=0", out_data_valid); end
    endtask

    task automatic test_fin_broadcast();
        do_reset();
        act_valid = 1; act_addr = 16'h8000; act_data = 16'h00AB; pe_idx = 6'd9;
        tick();
        act_valid = 0;
        tick();
        total++; if (out_data !== 36'h1_8000_00AB) begin bad++; $display("FIN_BC FAIL flit got=%h exp=1800000ab", out_data); end
        fin_comp = 1;
        tick();
        fin_comp = 0;
        tick();
        tick();
        total++; if (out_data_valid !== 1'b1 || out_data !== 36'h2_0000_0009)
            begin bad++; $display("FAIL fin_comp_flit got=%b/%h exp=1/200000009", out_data_valid, out_data); end
    endtask

    task automatic test_priority();
        do_reset();
        act_valid = 1; act_addr = 16'h0010; act_data = 16'hAAAA; fin_comp = 1;
        rd_valid = 1; rd_addr = 6'd3; pe_idx = 6'd9; rd_data = 16'hBEEF;
        #1;
        total++; if (act_ready !== 1'b1 || rd_ready !== 1'b0)
            begin bad++; $display("FAIL prio_ready got=%b%b exp=10", act_ready, rd_ready); end
        tick();
        act_valid = 0; fin_comp = 0;
        #1;
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL prio_rd_blocked got=%b exp=0", rd_ready); end
        tick();
        total++; if (out_data !== 36'h0_0010_AAAA) begin bad++; $display("FAIL prio_first got=%h exp=00010aaaa", out_data); end
        tick();
        rd_valid = 0;
        total++; if (out_data !== 36'h2_0000_0009) begin bad++; $display("FAIL prio_second got=%h exp=200000009", out_data); end
        tick();
        total++; if (out_data !== 36'h3_00C9_BEEF) begin bad++; $display("FAIL prio_third got=%h exp=300c9beef", out_data); end
    endtask

    task automatic test_backpressure();
        int accepted = 0, launches = 0;
        do_reset();
        act_valid = 1; act_addr = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            act_data = 16'(i);
            #1;
            if (act_ready) accepted++;
            tick();
            if (out_data_valid) launches++;
            total++; if (out_data !== m_od) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, out_data, m_od); end
        end
        #1;
        total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", act_ready); end
        total++; if (router_rdy !== 1'b0) begin bad++; $display("FAIL bp_router_rdy got=%b exp=0", router_rdy); end
        total++; if (accepted != 8 || launches != 4)
            begin bad++; $display("FAIL bp_counts got=%0d/%0d exp=8/4", accepted, launches); end
        act_valid = 0; downstream_credit = 1;
        tick();
        downstream_credit = 0;
        launches = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_data_valid) launches++;
        end
        total++; if (launches != 1) begin bad++; $display("FAIL bp_one_credit got=%0d exp=1", launches); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        fin_comp = 1;
        tick();
        fin_comp = 0; rst = 1;
        tick();
        rst = 0;
        total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_data_valid); end
        total++; if (router_rdy !== 1'b1) begin bad++; $display("FAIL mid_router_rdy got=%b exp=1", router_rdy); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_data_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_fin_merge();
        int fins = 0;
        do_reset();
        act_valid = 1; act_addr = 16'h0020; pe_idx = 6'd17;
        for (int i = 0; i < 8; i++) tick();
        act_valid = 0;
        fin_comp = 1; tick();
        fin_comp = 0; tick();
        fin_comp = 1; tick();
        fin_comp = 0;
        for (int i = 0; i < 20; i++) begin
            downstream_credit = m_cred < 4;
            tick();
            if (out_data_valid && out_data[35:32] == 4'h2) fins++;
            total++; if (out_data !== m_od) begin bad++; $display("FAIL merge_data cyc=%0d got=%h exp=%h", i, out_data, m_od); end
        end
        downstream_credit = 0;
        total++; if (fins != 1) begin bad++; $display("FAIL merge_count got=%0d exp=1", fins); end
        do_reset();
        fins = 0;
        fin_comp = 1; tick();
        tick();
        fin_comp = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_data_valid && out_data === 36'h2_0000_0011) fins++;
        end
        total++; if (fins != 2) begin bad++; $display("FAIL regrant_count got=%0d exp=2", fins); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(99) == 0;
            act_valid = $urandom_range(2) == 0;
            act_addr = 16'($urandom);
            act_data = 16'($urandom);
            fin_comp = $urandom_range(7) == 0;
            rd_valid = $urandom_range(1) == 0;
            rd_addr = 6'($urandom);
            rd_data = 16'($urandom);
            pe_idx = 6'($urandom);
            downstream_credit = m_cred < 4 && $urandom_range(2) != 0;
            #1;
            total++; if (act_ready !== (!rst && mq.size() < 4))
                begin bad++; $display("FAIL rnd_act_ready cyc=%0d got=%b", i, act_ready); end
            total++; if (rd_ready !== (!rst && mq.size() < 4 && !act_valid && !m_fin))
                begin bad++; $display("FAIL rnd_rd_ready cyc=%0d got=%b", i, rd_ready); end
            tick();
            total++; if (out_data_valid !== m_ov || out_data !== m_od)
                begin bad++; $display("FAIL rnd_out cyc=%0d got=%b/%h exp=%b/%h", i, out_data_valid, out_data, m_ov, m_od); end
            total++; if (router_rdy !== (m_cred > 0))
                begin bad++; $display("FAIL rnd_router_rdy cyc=%0d got=%b exp=%b", i, router_rdy, m_cred > 0); end
        end
        rst = 0; act_valid = 0; rd_valid = 0; fin_comp = 0; downstream_credit = 0;
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_fin_broadcast();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_fin_merge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
